// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory access path: funct3 codes, FSM
// state encoding and the request legality check.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_WRITE,
    ST_RESP
  } state_t;

  // An access is rejected for an unknown funct3 or a lane that does not fit the access size.
  function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    illegal    = we ? (funct3 > F3_W) : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts and extends load data, and merges store
// bytes/halfwords into the word read back from memory.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];
    unique case (funct3)
      F3_B:    load_data = 32'(lane_b);
      F3_H:    load_data = 32'(lane_h);
      F3_BU:   load_data = {24'h0, lane_b};
      F3_HU:   load_data = {16'h0, lane_h};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    store_word = rdata;
    unique case (funct3)
      F3_B:    store_word[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU request port and a registered-address data
// RAM; sub-word stores are done as read-modify-write.
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int ADDRW = 16
) (
  input  logic             sysCLK,
  input  logic             resetN,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [ADDRW-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata
);

  state_t      state;
  state_t      next_state;
  logic        accept;
  logic        req_error;
  logic        we_p0;
  logic [2:0]  funct3_p0;
  logic [1:0]  addr_lo_p0;
  logic [31:0] wdata_p0;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDRW+2];
  assign accept         = req_valid && req_ready;
  assign req_error      = access_err(req_we, req_funct3, req_addr[1:0]);

  always_ff @(posedge sysCLK or negedge resetN) begin
    if (!resetN) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_error)                          next_state = ST_RESP;
          else if (req_we && req_funct3 == F3_W)  next_state = ST_WRITE;
          else                                    next_state = ST_ISSUE;
        end
      end
      ST_ISSUE:   next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = we_p0 ? ST_WRITE : ST_RESP;
      ST_WRITE:   next_state = ST_RESP;
      ST_RESP:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
  end

  // Stage p0: request fields captured at acceptance, held for the whole access
  always_ff @(posedge sysCLK) begin
    if (accept) begin
      we_p0      <= req_we;
      funct3_p0  <= req_funct3;
      addr_lo_p0 <= req_addr[1:0];
      wdata_p0   <= req_wdata;
    end
  end

  mem_lane_align u_align (
    .funct3     (funct3_p0),
    .addr_lo    (addr_lo_p0),
    .rdata      (mem_rdata),
    .wdata      (wdata_p0),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Memory-side registers; mem_addr only moves for requests that will touch memory
  always_ff @(posedge sysCLK or negedge resetN) begin
    if (!resetN) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      if (accept && !req_error) mem_addr <= req_addr[ADDRW+1:2];
      if (accept && !req_error && req_we && req_funct3 == F3_W) mem_wdata <= req_wdata;
      else if (state == ST_CAPTURE && we_p0)                   mem_wdata <= store_word;
      mem_we <= (next_state == ST_WRITE);
    end
  end

  // Response registers are non-zero only for the single RESP cycle
  always_ff @(posedge sysCLK or negedge resetN) begin
    if (!resetN) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_rdata <= (state == ST_CAPTURE && next_state == ST_RESP) ? load_data : '0;
      rsp_err   <= (state == ST_IDLE && next_state == ST_RESP);
    end
  end

endmodule
